// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared constants and types for the pipeline-boundary register family.
// Replaces the old pipe_defs.vh include; every stage boundary imports this package.
package pipe_stage_skid_reg_pkg;

  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  // All-zero instruction word is the NOP the decoder treats as a bubble.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Occupancy of the boundary: bit 1 = head valid, bit 0 = skid valid.
  // 2'b01 (skid without head) is unreachable by construction.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_HEAD  = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  function automatic logic occ_head_valid(input logic [1:0] occ);
    return occ[1];
  endfunction

  function automatic logic occ_skid_valid(input logic [1:0] occ);
    return occ[0];
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating event counter: counts qualifying cycles, sticks at all-ones,
// cleared only by synchronous reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// One pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB): valid/ready handshake,
// hazard stall hold, flush-to-bubble, optional 2-entry skid, perf counters.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int unsigned        PC_W    = DEF_PC_W,
  parameter int unsigned        DATA_W  = DEF_DATA_W,
  parameter bit                 SKID_EN = 1'b1,
  parameter int unsigned        CNT_W   = DEF_CNT_W,
  parameter logic [DATA_W-1:0]  BUBBLE  = DATA_W'(NOP_INSN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  occ_e              occ_q;
  occ_e              occ_d;
  logic [PC_W-1:0]   head_pc_q;
  logic [PC_W-1:0]   head_pc_d;
  logic [DATA_W-1:0] head_data_q;
  logic [DATA_W-1:0] head_data_d;
  logic [PC_W-1:0]   skid_pc_q;
  logic [PC_W-1:0]   skid_pc_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;

  logic [1:0] occ_bits;
  logic       head_v;
  logic       skid_v;
  logic       room;
  logic       accept;
  logic       pop;
  logic       stall_inc;
  logic       flush_inc;

  assign occ_bits = occ_q;
  assign head_v   = occ_head_valid(occ_bits);
  assign skid_v   = occ_skid_valid(occ_bits);

  // With the skid enabled, readiness depends only on local state, so the
  // upstream ready path never sees out_ready combinationally.
  always_comb begin
    if (SKID_EN) begin
      room = ~skid_v;
    end else begin
      room = ~head_v | out_ready;
    end
    in_ready = ~stall & ~flush & room;
  end

  assign accept = in_valid & in_ready;
  // A stalled stage keeps its head even if downstream signals ready.
  assign pop    = head_v & out_ready & ~stall & ~flush;

  always_comb begin
    occ_d       = occ_q;
    head_pc_d   = head_pc_q;
    head_data_d = head_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      occ_d       = OCC_EMPTY;
      head_pc_d   = '0;
      head_data_d = BUBBLE;
      skid_pc_d   = '0;
      skid_data_d = BUBBLE;
    end else if (!stall) begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d       = OCC_HEAD;
            head_pc_d   = in_pc;
            head_data_d = in_data;
          end
        end
        OCC_HEAD: begin
          if (accept && pop) begin
            head_pc_d   = in_pc;
            head_data_d = in_data;
          end else if (accept && SKID_EN) begin
            occ_d       = OCC_FULL;
            skid_pc_d   = in_pc;
            skid_data_d = in_data;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            occ_d       = OCC_HEAD;
            head_pc_d   = skid_pc_q;
            head_data_d = skid_data_q;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      head_pc_q   <= '0;
      head_data_q <= BUBBLE;
      skid_pc_q   <= '0;
      skid_data_q <= BUBBLE;
    end else begin
      occ_q       <= occ_d;
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid = head_v;
  assign out_pc    = head_pc_q;
  assign out_data  = head_data_q;

  assign stall_inc = stall & ~flush;
  assign flush_inc = flush & (head_v | skid_v);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst) !(skid_v && !head_v))
    else $error("skid entry held without a head entry");

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: three configurations driven by shared stimulus,
// each checked against a FIFO-level reference model, plus a directed vector table.
module tb_pipe_stage_skid_reg;

  localparam int unsigned NDUT = 3;
  localparam logic [31:0] BUB  = 32'h0000_0013;
  localparam logic [31:0] KEY  = 32'h5A00_0000;

  logic        clk = 1'b0;
  logic        rst, flush, stall, in_valid, out_ready;
  logic [31:0] in_pc, in_data;

  logic        a_ov, a_ir, b_ov, b_ir, c_ov, c_ir;
  logic [31:0] a_pc, a_dat, b_pc, b_dat, c_pc, c_dat;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [1:0]  c_sc, c_fc;

  logic        ov   [NDUT];
  logic        ir   [NDUT];
  logic [31:0] opc  [NDUT];
  logic [31:0] odat [NDUT];
  logic [15:0] scnt [NDUT];
  logic [15:0] fcnt [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.PC_W(32), .DATA_W(32), .SKID_EN(1'b1), .CNT_W(16), .BUBBLE(BUB)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(a_ir), .in_pc(in_pc), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_pc(a_pc), .out_data(a_dat),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipe_stage_skid_reg #(.PC_W(32), .DATA_W(32), .SKID_EN(1'b0), .CNT_W(16), .BUBBLE(BUB)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(b_ir), .in_pc(in_pc), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_pc(b_pc), .out_data(b_dat),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  pipe_stage_skid_reg #(.PC_W(32), .DATA_W(32), .SKID_EN(1'b1), .CNT_W(2), .BUBBLE(BUB)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(c_ir), .in_pc(in_pc), .in_data(in_data),
    .out_valid(c_ov), .out_ready(out_ready), .out_pc(c_pc), .out_data(c_dat),
    .stall_cnt(c_sc), .flush_cnt(c_fc)
  );

  always_comb begin
    ov[0] = a_ov; ir[0] = a_ir; opc[0] = a_pc; odat[0] = a_dat; scnt[0] = a_sc; fcnt[0] = a_fc;
    ov[1] = b_ov; ir[1] = b_ir; opc[1] = b_pc; odat[1] = b_dat; scnt[1] = b_sc; fcnt[1] = b_fc;
    ov[2] = c_ov; ir[2] = c_ir; opc[2] = c_pc; odat[2] = c_dat;
    scnt[2] = {14'd0, c_sc}; fcnt[2] = {14'd0, c_fc};
  end

  // Reference model: each boundary is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [31:0] m_pc  [NDUT][2];
  logic [31:0] m_dat [NDUT][2];
  int unsigned m_n   [NDUT];
  bit          m_bub [NDUT];
  int unsigned m_sc  [NDUT];
  int unsigned m_fc  [NDUT];
  bit          model_ok = 1'b0;

  function automatic bit skid_of(input int unsigned d);
    return d != 1;
  endfunction

  function automatic int unsigned cmax_of(input int unsigned d);
    return (d == 2) ? 3 : 65535;
  endfunction

  function automatic bit m_ready(input int unsigned d);
    if (stall || flush) return 1'b0;
    if (skid_of(d)) return m_n[d] < 2;
    return (m_n[d] == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    if (!model_ok) return;
    for (int unsigned d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(m_n[d] != 0));
      chk($sformatf("d%0d_in_ready", d), 32'(ir[d]), 32'(m_ready(d)));
      if (m_n[d] != 0) begin
        chk($sformatf("d%0d_out_pc", d), opc[d], m_pc[d][0]);
        chk($sformatf("d%0d_out_data", d), odat[d], m_dat[d][0]);
      end else if (m_bub[d]) begin
        chk($sformatf("d%0d_bubble_pc", d), opc[d], 32'h0);
        chk($sformatf("d%0d_bubble_data", d), odat[d], BUB);
      end
      chk($sformatf("d%0d_stall_cnt", d), 32'(scnt[d]), m_sc[d]);
      chk($sformatf("d%0d_flush_cnt", d), 32'(fcnt[d]), m_fc[d]);
    end
  endtask

  task automatic model_edge();
    for (int unsigned d = 0; d < NDUT; d++) begin
      bit rdy;
      rdy = m_ready(d);
      if (rst) begin
        m_n[d] = 0; m_sc[d] = 0; m_fc[d] = 0; m_bub[d] = 1'b1;
      end else if (flush) begin
        if (m_n[d] > 0 && m_fc[d] < cmax_of(d)) m_fc[d]++;
        m_n[d] = 0; m_bub[d] = 1'b1;
      end else if (stall) begin
        if (m_sc[d] < cmax_of(d)) m_sc[d]++;
      end else begin
        if (m_n[d] > 0 && out_ready) begin
          m_pc[d][0] = m_pc[d][1]; m_dat[d][0] = m_dat[d][1]; m_n[d]--;
        end
        if (in_valid && rdy) begin
          m_pc[d][m_n[d]] = in_pc; m_dat[d][m_n[d]] = in_data; m_n[d]++; m_bub[d] = 1'b0;
        end
      end
    end
    if (rst) model_ok = 1'b1;
  endtask

  task automatic drive(input bit r, input bit f, input bit s, input bit v,
                       input logic [31:0] pc, input bit ordy);
    rst = r; flush = f; stall = s; in_valid = v; in_pc = pc; in_data = pc ^ KEY; out_ready = ordy;
  endtask

  task automatic pre_check();
    #1;
    model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // pd: 0 = don't check pc/data, 1 = expect entry e_pc, 2 = expect bubble
  typedef struct {
    bit          r, f, s, v;
    logic [31:0] pc;
    bit          ordy;
    bit          chk_en;
    bit          e_ov, e_ir;
    int unsigned pd;
    logic [31:0] e_pc;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit f, input bit s, input bit v,
                              input logic [31:0] pc, input bit ordy, input bit c,
                              input bit eov, input bit eir, input int unsigned pd,
                              input logic [31:0] epc, input logic [15:0] esc,
                              input logic [15:0] efc);
    vec_t t;
    t.r = r; t.f = f; t.s = s; t.v = v; t.pc = pc; t.ordy = ordy; t.chk_en = c;
    t.e_ov = eov; t.e_ir = eir; t.pd = pd; t.e_pc = epc; t.e_sc = esc; t.e_fc = efc;
    return t;
  endfunction

  vec_t tbl [22];
  logic [31:0] pc_next;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    //                r  f  s  v  pc     rdy chk ov ir pd  e_pc   sc fc
    tbl[0]  = mk(1, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h00, 0, 1, 0, 1, 2, 32'h00, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 32'h00, 1, 1, 0, 1, 2, 32'h00, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 32'h04, 1, 1, 1, 1, 1, 32'h00, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 32'h08, 1, 1, 1, 1, 1, 32'h04, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 32'h00, 1, 1, 1, 1, 1, 32'h08, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 32'h10, 0, 1, 0, 1, 0, 32'h00, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 32'h14, 0, 1, 1, 1, 1, 32'h10, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 32'h18, 0, 1, 1, 0, 1, 32'h10, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h00, 1, 1, 1, 0, 1, 32'h10, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 32'h00, 1, 1, 1, 1, 1, 32'h14, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 32'h20, 0, 1, 0, 1, 0, 32'h00, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, 32'h24, 1, 1, 1, 0, 1, 32'h20, 0, 0);
    tbl[13] = mk(0, 0, 1, 1, 32'h24, 1, 1, 1, 0, 1, 32'h20, 1, 0);
    tbl[14] = mk(0, 0, 1, 1, 32'h24, 1, 1, 1, 0, 1, 32'h20, 2, 0);
    tbl[15] = mk(0, 0, 0, 1, 32'h24, 0, 1, 1, 1, 1, 32'h20, 3, 0);
    tbl[16] = mk(0, 1, 1, 1, 32'h28, 1, 1, 1, 0, 1, 32'h20, 3, 0);
    tbl[17] = mk(0, 0, 0, 0, 32'h00, 1, 1, 0, 1, 2, 32'h00, 3, 1);
    tbl[18] = mk(0, 1, 0, 0, 32'h00, 1, 1, 0, 0, 2, 32'h00, 3, 1);
    tbl[19] = mk(0, 0, 0, 0, 32'h00, 1, 1, 0, 1, 2, 32'h00, 3, 1);
    tbl[20] = mk(1, 0, 1, 1, 32'h30, 1, 1, 0, 0, 2, 32'h00, 3, 1);
    tbl[21] = mk(0, 0, 0, 0, 32'h00, 1, 1, 0, 1, 2, 32'h00, 0, 0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].pc, tbl[i].ordy);
      pre_check();
      if (tbl[i].chk_en) begin
        chk($sformatf("tbl%0d_out_valid", i), 32'(a_ov), 32'(tbl[i].e_ov));
        chk($sformatf("tbl%0d_in_ready", i), 32'(a_ir), 32'(tbl[i].e_ir));
        if (tbl[i].pd == 1) begin
          chk($sformatf("tbl%0d_out_pc", i), a_pc, tbl[i].e_pc);
          chk($sformatf("tbl%0d_out_data", i), a_dat, tbl[i].e_pc ^ KEY);
        end else if (tbl[i].pd == 2) begin
          chk($sformatf("tbl%0d_bubble_pc", i), a_pc, 32'h0);
          chk($sformatf("tbl%0d_bubble_data", i), a_dat, BUB);
        end
        chk($sformatf("tbl%0d_stall_cnt", i), 32'(a_sc), 32'(tbl[i].e_sc));
        chk($sformatf("tbl%0d_flush_cnt", i), 32'(a_fc), 32'(tbl[i].e_fc));
      end
      edge_step();
    end

    // Long stall: narrow counter must stick at 3 while the wide ones reach 6.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    pre_check();
    edge_step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      pre_check();
      edge_step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    pre_check();
    chk("sat_stall_cnt_w2", 32'(c_sc), 32'd3);
    chk("stall_cnt_w16_skid", 32'(a_sc), 32'd6);
    chk("stall_cnt_w16_noskid", 32'(b_sc), 32'd6);
    edge_step();

    pc_next = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 75, pc_next, $urandom_range(0, 99) < 60);
      pc_next = pc_next + 32'd4;
      pre_check();
      edge_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
